// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port byte-memory arbiter.
//   state_e : controller states (IDLE, BEAT, LAST, RESP)
//   BEATS   : bytes per 64-bit word transfer
//   PORT_F / PORT_D : encoding of the granted port (fetch / data)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        LAST = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int unsigned BEATS = 8;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant picker.
//   req_f, req_d : pending requests from the fetch and data ports
//   last_grant   : port granted most recently (PORT_F / PORT_D)
//   grant        : selected port; only meaningful when a request is present
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req_f,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = PORT_F;
        if (req_f && req_d) begin
            // Tie: the port that was not served last time wins.
            grant = ~last_grant;
        end else if (req_d) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch (read-only) port and a data (read/write) port onto a
// byte-wide memory, moving one 64-bit little-endian word per request as
// BEATS single-byte accesses.
//   clk, rst                 : clock, synchronous active-high reset
//   f_req/f_addr             : fetch request and byte address
//   f_ack/f_err/f_rdata      : fetch completion pulse, range error, read word
//   d_req/d_we/d_addr/d_wdata: data request, write enable, address, write word
//   d_ack/d_err/d_rdata      : data completion pulse, range error, read word
//   m_en/m_we/m_addr/m_wdata : byte-memory strobe, write enable, address, byte
//   m_rdata                  : byte-memory read data, one cycle after m_en
module mem_port_arbiter #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BEATS     = mem_arb_pkg::BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_ack,
    output logic        f_err,
    output logic [63:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata
);
    import mem_arb_pkg::*;

    localparam int unsigned     CntW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BEATS - 1);
    // Highest base address whose whole word still fits in memory.
    localparam logic [63:0]     MaxBase = 64'(MEM_BYTES - BEATS);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            port_q, port_d;
    logic            err_q, err_d;
    logic            last_q, last_d;
    logic            rd_pend_q, rd_pend_d;
    logic [CntW-1:0] rd_idx_q, rd_idx_d;
    logic [63:0]     f_rdata_q, f_rdata_d;
    logic [63:0]     d_rdata_q, d_rdata_d;

    logic            grant;
    logic [63:0]     sel_addr;
    logic            ack;

    mem_arb_rr u_rr (
        .req_f      (f_req),
        .req_d      (d_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign sel_addr = (grant == PORT_D) ? d_addr : f_addr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        port_d    = port_q;
        err_d     = err_q;
        last_d    = last_q;
        rd_pend_d = 1'b0;
        rd_idx_d  = cnt_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = 64'h0;
        m_wdata   = 8'h00;
        ack       = 1'b0;

        // Byte requested in the previous cycle arrives now.
        if (rd_pend_q) begin
            if (port_q == PORT_D) begin
                d_rdata_d[8*rd_idx_q +: 8] = m_rdata;
            end else begin
                f_rdata_d[8*rd_idx_q +: 8] = m_rdata;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    port_d  = grant;
                    last_d  = grant;
                    addr_d  = sel_addr;
                    we_d    = (grant == PORT_D) && d_we;
                    wdata_d = (grant == PORT_D) ? d_wdata : 64'h0;
                    cnt_d   = '0;
                    err_d   = (sel_addr > MaxBase);
                    state_d = (sel_addr > MaxBase) ? RESP : BEAT;
                end
            end
            BEAT: begin
                m_en      = 1'b1;
                m_we      = we_q;
                m_addr    = addr_q + 64'(cnt_q);
                m_wdata   = we_q ? wdata_q[8*cnt_q +: 8] : 8'h00;
                rd_pend_d = ~we_q;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = LAST;
                end
            end
            LAST: begin
                state_d = RESP;
            end
            RESP: begin
                // Error responses spend one extra cycle here so the ack lands
                // two cycles after the grant.
                if (err_q && (cnt_q == '0)) begin
                    cnt_d = CntW'(1);
                end else begin
                    ack     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= 64'h0;
            wdata_q   <= 64'h0;
            we_q      <= 1'b0;
            port_q    <= PORT_F;
            err_q     <= 1'b0;
            last_q    <= PORT_F;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            f_rdata_q <= 64'h0;
            d_rdata_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            port_q    <= port_d;
            err_q     <= err_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign f_ack   = ack && (port_q == PORT_F);
    assign d_ack   = ack && (port_q == PORT_D);
    assign f_err   = f_ack && err_q;
    assign d_err   = d_ack && err_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_ack, f_err;
    logic [63:0] f_addr, f_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        m_en, m_we;
    logic [63:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_BYTES(1024), .BEATS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_ack   (f_ack),
        .f_err   (f_err),
        .f_rdata (f_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    // Byte memory model with a side port for preloading.
    logic [7:0] mem [1024];
    logic       pre_we = 1'b0;
    logic [9:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (m_en && m_we) mem[m_addr[9:0]] <= m_wdata;
        if (m_en && !m_we) m_rdata <= mem[m_addr[9:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus-quiet and single-ack watchers.
    logic mon_on = 1'b0;
    int   idle_viol = 0;
    int   dual_ack = 0;
    always @(negedge clk) begin
        if (mon_on && !m_en && (m_we !== 1'b0 || m_wdata !== 8'h00)) idle_viol <= idle_viol + 1;
        if (mon_on && f_ack && d_ack) dual_ack <= dual_ack + 1;
    end

    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Per-transaction capture written by run_txn.
    int          cap_n;
    logic [63:0] cap_addr [8];
    logic [7:0]  cap_wd [8];
    int          cap_lat [8];
    logic        cap_we_bad;
    int          ack_lat;
    logic        ack_f, ack_d, ack_err;
    logic [63:0] cap_f, cap_d;

    task automatic preload(input int a, input logic [7:0] v);
        pre_we = 1'b1;
        pre_addr = a[9:0];
        pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drives one request from an IDLE cycle and records the bus and the ack.
    task automatic run_txn(input logic port, input logic [63:0] addr, input logic we,
                           input logic [63:0] wdata, input bit scramble);
        int t0;
        @(negedge clk);
        cap_n = 0; cap_we_bad = 1'b0; ack_lat = -1;
        ack_f = 1'b0; ack_d = 1'b0; ack_err = 1'b0;
        if (port == PORT_D) begin
            d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (scramble) begin
                f_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
            end
            if (m_en) begin
                if (cap_n < 8) begin
                    cap_addr[cap_n] = m_addr;
                    cap_wd[cap_n] = m_wdata;
                    cap_lat[cap_n] = cyc - t0;
                end
                cap_n++;
                if (m_we !== we) cap_we_bad = 1'b1;
            end
            if (f_ack || d_ack) begin
                ack_lat = cyc - t0;
                ack_f = f_ack; ack_d = d_ack;
                ack_err = (port == PORT_D) ? d_err : f_err;
                cap_f = f_rdata; cap_d = d_rdata;
                break;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({f_ack, d_ack, f_err, d_err, m_en, m_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {f_ack, d_ack, f_err, d_err, m_en, m_we});
        end
        n_checks++;
        if (m_addr !== 64'h0) begin
            n_fail++; $display("FAIL reset_m_addr: got %h expected 0", m_addr);
        end
        n_checks++;
        if (m_wdata !== 8'h0) begin
            n_fail++; $display("FAIL reset_m_wdata: got %h expected 0", m_wdata);
        end
        n_checks++;
        if ({f_rdata, d_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", f_rdata, d_rdata);
        end
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_fetch;
        exp_t e;
        sb.push_back('{port: PORT_F, err: 1'b0, rdata: 64'h0807060504030201});
        run_txn(PORT_F, 64'h10, 1'b0, 64'h0, 1'b1);
        n_checks++;
        if (cap_n !== 8) begin n_fail++; $display("FAIL fetch_beats: got %0d expected 8", cap_n); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (cap_addr[k] !== 64'h10 + 64'(k) || cap_lat[k] !== k + 1) begin
                n_fail++;
                $display("FAIL fetch_beat%0d: got addr %h at T+%0d expected addr %h at T+%0d",
                         k, cap_addr[k], cap_lat[k], 64'h10 + 64'(k), k + 1);
            end
        end
        n_checks++;
        if (cap_we_bad !== 1'b0) begin n_fail++; $display("FAIL fetch_m_we: got 1 expected 0"); end
        n_checks++;
        if (ack_lat !== 10) begin n_fail++; $display("FAIL fetch_lat: got %0d expected 10", ack_lat); end
        e = sb.pop_front();
        n_checks++;
        if ({ack_f, ack_d, ack_err} !== {e.port == PORT_F, e.port == PORT_D, e.err}) begin
            n_fail++; $display("FAIL fetch_ack: got %b%b%b expected 100", ack_f, ack_d, ack_err);
        end
        n_checks++;
        if (cap_f !== e.rdata) begin n_fail++; $display("FAIL fetch_rdata: got %h expected %h", cap_f, e.rdata); end
    endtask

    task automatic test_write;
        exp_t        e;
        logic [63:0] wd;
        logic [63:0] memw;
        wd = 64'h1122334455667788;
        // Give d_rdata a known value first so the write can be seen not to touch it.
        sb.push_back('{port: PORT_D, err: 1'b0, rdata: 64'h0807060504030201});
        run_txn(PORT_D, 64'h10, 1'b0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!ack_d || ack_lat !== 10 || cap_d !== e.rdata) begin
            n_fail++; $display("FAIL data_read10: got ack %b lat %0d rdata %h expected 1 10 %h",
                               ack_d, ack_lat, cap_d, e.rdata);
        end
        sb.push_back('{port: PORT_D, err: 1'b0, rdata: 64'h0807060504030201});
        run_txn(PORT_D, 64'h20, 1'b1, wd, 1'b1);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (cap_addr[k] !== 64'h20 + 64'(k) || cap_wd[k] !== wd[8*k +: 8]) begin
                n_fail++;
                $display("FAIL write_beat%0d: got %h@%h expected %h@%h",
                         k, cap_wd[k], cap_addr[k], wd[8*k +: 8], 64'h20 + 64'(k));
            end
        end
        n_checks++;
        if (cap_n !== 8 || cap_we_bad !== 1'b0) begin
            n_fail++; $display("FAIL write_bus: got beats %0d we_bad %b expected 8 0", cap_n, cap_we_bad);
        end
        n_checks++;
        if (ack_lat !== 10) begin n_fail++; $display("FAIL write_lat: got %0d expected 10", ack_lat); end
        e = sb.pop_front();
        n_checks++;
        if (!ack_d || ack_f || ack_err !== e.err || cap_d !== e.rdata) begin
            n_fail++; $display("FAIL write_resp: got ack %b%b err %b rdata %h expected 01 0 %h",
                               ack_f, ack_d, ack_err, cap_d, e.rdata);
        end
        for (int k = 0; k < 8; k++) memw[8*k +: 8] = mem[32 + k];
        n_checks++;
        if (memw !== wd) begin n_fail++; $display("FAIL write_mem: got %h expected %h", memw, wd); end
        sb.push_back('{port: PORT_D, err: 1'b0, rdata: wd});
        run_txn(PORT_D, 64'h20, 1'b0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!ack_d || cap_d !== e.rdata || cap_f !== 64'h0807060504030201) begin
            n_fail++; $display("FAIL data_readback: got d %h f %h expected d %h f 0807060504030201",
                               cap_d, cap_f, e.rdata);
        end
    endtask

    task automatic test_round_robin;
        exp_t e;
        logic got;
        int   n_ack;
        int   ack_cyc [4];
        int   first_en;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{port: PORT_D, err: 1'b0, rdata: 64'h1122334455667788});
        sb.push_back('{port: PORT_F, err: 1'b0, rdata: 64'h0807060504030201});
        sb.push_back('{port: PORT_D, err: 1'b0, rdata: 64'h1122334455667788});
        sb.push_back('{port: PORT_F, err: 1'b0, rdata: 64'h0807060504030201});
        f_req = 1'b1; f_addr = 64'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
        n_ack = 0; first_en = -1;
        for (int i = 0; i < 80 && n_ack < 4; i++) begin
            @(negedge clk);
            if (m_en && n_ack == 1 && first_en < 0) first_en = cyc;
            if (f_ack || d_ack) begin
                got = d_ack ? PORT_D : PORT_F;
                ack_cyc[n_ack] = cyc;
                n_ack++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rr_sb: got ack %0d expected none", n_ack);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.port || (got ? d_rdata : f_rdata) !== e.rdata) begin
                        n_fail++;
                        $display("FAIL rr_ack%0d: got port %b rdata %h expected port %b rdata %h",
                                 n_ack, got, got ? d_rdata : f_rdata, e.port, e.rdata);
                    end
                end
                if (n_ack == 1) d_req = 1'b0;
                if (n_ack == 2) d_req = 1'b1;
                if (n_ack == 3) d_req = 1'b0;
                if (n_ack == 4) f_req = 1'b0;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (n_ack !== 4) begin n_fail++; $display("FAIL rr_count: got %0d expected 4", n_ack); end
        n_checks++;
        if (n_ack >= 3 && (ack_cyc[1] - ack_cyc[0] !== 11 || ack_cyc[2] - ack_cyc[1] !== 11)) begin
            n_fail++; $display("FAIL rr_gap: got %0d %0d expected 11 11",
                               ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
        end
        n_checks++;
        if (first_en !== ack_cyc[0] + 2) begin
            n_fail++; $display("FAIL rr_fetch_start: got %0d expected %0d", first_en, ack_cyc[0] + 2);
        end
    endtask

    task automatic test_out_of_range;
        exp_t        e;
        logic [63:0] prev_d;
        logic [63:0] prev_f;
        prev_d = d_rdata;
        prev_f = f_rdata;
        sb.push_back('{port: PORT_D, err: 1'b1, rdata: 64'h1122334455667788});
        run_txn(PORT_D, 64'h3F9, 1'b0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (ack_lat !== 2 || cap_n !== 0 || !ack_d || ack_err !== e.err || cap_d !== e.rdata) begin
            n_fail++; $display("FAIL oor_3f9: got lat %0d beats %0d ack %b err %b rdata %h expected 2 0 1 1 %h",
                               ack_lat, cap_n, ack_d, ack_err, cap_d, e.rdata);
        end
        sb.push_back('{port: PORT_D, err: 1'b1, rdata: 64'h1122334455667788});
        run_txn(PORT_D, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (ack_lat !== 2 || cap_n !== 0 || !ack_d || ack_err !== e.err || cap_d !== e.rdata) begin
            n_fail++; $display("FAIL oor_wrap: got lat %0d beats %0d ack %b err %b rdata %h expected 2 0 1 1 %h",
                               ack_lat, cap_n, ack_d, ack_err, cap_d, e.rdata);
        end
        sb.push_back('{port: PORT_F, err: 1'b0, rdata: 64'hA7A6A5A4A3A2A1A0});
        run_txn(PORT_F, 64'h3F8, 1'b0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (ack_lat !== 10 || cap_n !== 8 || !ack_f || ack_err !== e.err || cap_f !== e.rdata) begin
            n_fail++; $display("FAIL edge_3f8: got lat %0d beats %0d ack %b err %b rdata %h expected 10 8 1 0 %h",
                               ack_lat, cap_n, ack_f, ack_err, cap_f, e.rdata);
        end
        sb.push_back('{port: PORT_F, err: 1'b1, rdata: 64'hA7A6A5A4A3A2A1A0});
        run_txn(PORT_F, 64'h3F9, 1'b0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (ack_lat !== 2 || cap_n !== 0 || !ack_f || ack_err !== e.err || cap_f !== e.rdata) begin
            n_fail++; $display("FAIL oor_fetch: got lat %0d beats %0d ack %b err %b rdata %h expected 2 0 1 1 %h",
                               ack_lat, cap_n, ack_f, ack_err, cap_f, e.rdata);
        end
        n_checks++;
        if (prev_d !== 64'h1122334455667788 || prev_f !== 64'h0807060504030201) begin
            n_fail++; $display("FAIL oor_prev: got d %h f %h expected 1122334455667788 0807060504030201",
                               prev_d, prev_f);
        end
    endtask

    task automatic test_reset_abort;
        logic        hit;
        int          bad_ack;
        int          bad_en;
        logic [31:0] lo;
        logic [31:0] hi;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'hC7C6C5C4C3C2C1C0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_en && m_addr === 64'h43) begin
                hit = 1'b1;
                break;
            end
        end
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!hit || m_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_m_en: got hit %b m_en %b expected 1 0", hit, m_en);
        end
        rst = 1'b0;
        bad_ack = 0; bad_en = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (d_ack || f_ack) bad_ack++;
            if (m_en) bad_en++;
        end
        n_checks++;
        if (bad_ack !== 0 || bad_en !== 0) begin
            n_fail++; $display("FAIL abort_quiet: got acks %0d beats %0d expected 0 0", bad_ack, bad_en);
        end
        for (int k = 0; k < 4; k++) begin
            lo[8*k +: 8] = mem[64 + k];
            hi[8*k +: 8] = mem[68 + k];
        end
        n_checks++;
        if (lo !== 32'hC3C2C1C0 || hi !== 32'hEEEEEEEE) begin
            n_fail++; $display("FAIL abort_mem: got %h %h expected eeeeeeee c3c2c1c0", hi, lo);
        end
        n_checks++;
        if (d_rdata !== 64'h0) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0", d_rdata); end
    endtask

    task automatic test_bus_quiet;
        n_checks++;
        if (idle_viol !== 0 || dual_ack !== 0) begin
            n_fail++; $display("FAIL bus_quiet: got idle_viol %0d dual_ack %0d expected 0 0", idle_viol, dual_ack);
        end
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_left: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = 64'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            preload(16 + k, 8'(k + 1));
            preload(32 + k, 8'h00);
            preload(64 + k, 8'hEE);
            preload(1016 + k, 8'hA0 + 8'(k));
        end
        test_reset();
        test_fetch();
        test_write();
        test_round_robin();
        test_out_of_range();
        test_reset_abort();
        test_bus_quiet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
